dcache_ctrl: RTL and testbench

- Miss/refill and write-through controller for the direct-mapped data cache in the Memory stage of the pipelined core.
- Observes each load/store in M together with the cache's hit signal.
- Sequences multi-cycle transactions on the data memory port, writes refilled or updated words into the cache, and holds the pipeline stalled while a transaction is outstanding.

---
 rtl/dcache_ctrl_if.sv | 41 ++++
 rtl/dcache_ctrl.sv | 166 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_ctrl_if.sv
// ============================================================================
//  Module   : dcache_ctrl_if
//  Purpose  : Pipeline, cache-fill and data-memory signals of the D-cache controller.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface dcache_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  hit;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  err;

  // Environment side: the pipeline, the cache tag logic and the data memory.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, hit, mem_ready, mem_rdata,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata, fill_we, fill_addr, fill_data, err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, hit, mem_ready, mem_rdata,
    output stall, mem_req, mem_we, mem_addr, mem_wdata, fill_we, fill_addr, fill_data, err
  );
endinterface

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
//  Module   : dcache_ctrl
//  Purpose  : Miss/refill and write-through controller for the direct-mapped
//             D-cache; optional hit/miss counters under DCACHE_PERF_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_WIDTH       = 7
) (
  input  logic         clk,
  input  logic         rst,
  dcache_ctrl_if.slave bus
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_WAIT = 3'd2,
    S_FILL    = 3'd3,
    S_ACK     = 3'd4
  } state_t;

  localparam logic [TO_WIDTH-1:0] c_TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TO_WIDTH-1:0] c_TO_ONE   = TO_WIDTH'(1);

  state_t                r_state;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_fill_we;
  logic [ADDR_WIDTH-1:0] r_fill_addr;
  logic [DATA_WIDTH-1:0] r_fill_data;
  logic                  r_hit_l;
  logic                  r_err;
  logic [TO_WIDTH-1:0]   r_to_cnt;

  logic [ADDR_WIDTH-1:0] w_addr_aligned;
  logic [TO_WIDTH-1:0]   w_to_next;
  logic                  w_idle_start;
  logic                  w_idle_hit;
  logic                  w_in_wait;

  assign w_addr_aligned = bus.req_addr & ~ADDR_WIDTH'(3);
  assign w_to_next      = r_to_cnt + c_TO_ONE;
  assign w_in_wait      = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
  assign w_idle_start   = (r_state == S_IDLE) && bus.req_valid && (bus.req_write || !bus.hit);
  assign w_idle_hit     = (r_state == S_IDLE) && bus.req_valid && !bus.req_write && bus.hit;

  // The miss is flagged in its detect cycle, before the FSM has left IDLE.
  assign bus.stall     = w_idle_start || w_in_wait || (r_state == S_FILL);
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.fill_we   = r_fill_we;
  assign bus.fill_addr = r_fill_addr;
  assign bus.fill_data = r_fill_data;
  assign bus.err       = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_fill_we   <= 1'b0;
      r_fill_addr <= '0;
      r_fill_data <= '0;
      r_hit_l     <= 1'b0;
      r_err       <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_fill_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid && bus.req_write) begin
            r_mem_addr  <= w_addr_aligned;
            r_mem_wdata <= bus.req_wdata;
            r_hit_l     <= bus.hit;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_to_cnt    <= '0;
            r_state     <= S_WR_WAIT;
          end else if (bus.req_valid && !bus.hit) begin
            r_mem_addr  <= w_addr_aligned;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_to_cnt    <= '0;
            r_state     <= S_RD_WAIT;
          end
        end

        S_RD_WAIT, S_WR_WAIT: begin
          // Completion takes priority over a timeout reached in the same cycle.
          if (bus.mem_ready) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_state == S_RD_WAIT) begin
              r_fill_data <= bus.mem_rdata;
              r_fill_addr <= r_mem_addr;
              r_fill_we   <= 1'b1;
              r_state     <= S_FILL;
            end else if (r_hit_l) begin
              r_fill_data <= r_mem_wdata;
              r_fill_addr <= r_mem_addr;
              r_fill_we   <= 1'b1;
              r_state     <= S_FILL;
            end else begin
              r_state     <= S_ACK;
            end
          end else if (w_to_next == c_TO_LIMIT) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_err     <= 1'b1;
            r_to_cnt  <= w_to_next;
            r_state   <= S_ACK;
          end else begin
            r_to_cnt  <= w_to_next;
          end
        end

        S_FILL:  r_state <= S_ACK;
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // Only IDLE cycles count, so the retiring ACK-cycle hit after a refill is excluded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_idle_hit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_idle_start && !bus.req_write && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ============================================================================
//  Module   : tb_dcache_ctrl
//  Purpose  : Directed self-checking bench for dcache_ctrl (DCACHE_PERF_EN aware).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dcache_ctrl;
  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  dcache_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_ctrl #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(64),
    .TO_WIDTH      (7)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave)
`ifdef DCACHE_PERF_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic v, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic h);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.hit       = h;
    #1;
  endtask

`ifdef DCACHE_PERF_EN
  task automatic load_miss_quick(input logic [31:0] a);
    req(1'b1, 1'b0, a, 32'h0, 1'b0);
    step();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = a;
    step();
    bus.mem_ready = 1'b0;
    req(1'b1, 1'b0, a, 32'h0, 1'b1);
    step();
    req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("rst_mem_req",  {31'b0, bus.mem_req}, 32'd0);
    chk("rst_stall",    {31'b0, bus.stall},   32'd0);
    chk("rst_err",      {31'b0, bus.err},     32'd0);
    chk("rst_fill_we",  {31'b0, bus.fill_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr,         32'h0);
    rst = 1'b1;
    step();

    // Load miss at 0x104, latency 2.
    req(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0);
    chk("lm_stall_detect", {31'b0, bus.stall}, 32'd1);
    step();
    chk("lm_w1_req",   {31'b0, bus.mem_req}, 32'd1);
    chk("lm_w1_we",    {31'b0, bus.mem_we},  32'd0);
    chk("lm_w1_addr",  bus.mem_addr,         32'h0000_0104);
    chk("lm_w1_stall", {31'b0, bus.stall},   32'd1);
    step();
    chk("lm_w2_req",   {31'b0, bus.mem_req}, 32'd1);
    chk("lm_w2_stall", {31'b0, bus.stall},   32'd1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    bus.mem_ready = 1'b0;
    chk("lm_fill_we",   {31'b0, bus.fill_we}, 32'd1);
    chk("lm_fill_data", bus.fill_data,        32'hDEAD_BEEF);
    chk("lm_fill_addr", bus.fill_addr,        32'h0000_0104);
    chk("lm_fill_req",  {31'b0, bus.mem_req}, 32'd0);
    chk("lm_fill_stall", {31'b0, bus.stall},  32'd1);
    req(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b1);
    step();
    chk("lm_ack_stall", {31'b0, bus.stall},   32'd0);
    chk("lm_ack_fill",  {31'b0, bus.fill_we}, 32'd0);
    req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();

    // Store hit to 0x10, latency 1.
    req(1'b1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1);
    chk("sh_stall_detect", {31'b0, bus.stall}, 32'd1);
    step();
    chk("sh_we",    {31'b0, bus.mem_we}, 32'd1);
    chk("sh_wdata", bus.mem_wdata,       32'h1234_5678);
    chk("sh_addr",  bus.mem_addr,        32'h0000_0010);
    chk("sh_w_stall", {31'b0, bus.stall}, 32'd1);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("sh_fill_we",   {31'b0, bus.fill_we}, 32'd1);
    chk("sh_fill_data", bus.fill_data,        32'h1234_5678);
    chk("sh_fill_addr", bus.fill_addr,        32'h0000_0010);
    chk("sh_fill_stall", {31'b0, bus.stall},  32'd1);
    step();
    chk("sh_ack_stall", {31'b0, bus.stall}, 32'd0);
    req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();

    // Store miss to 0x22 (aligned to 0x20): write-no-allocate.
    req(1'b1, 1'b1, 32'h0000_0022, 32'hAABB_CCDD, 1'b0);
    step();
    chk("sm_we",    {31'b0, bus.mem_we}, 32'd1);
    chk("sm_addr",  bus.mem_addr,        32'h0000_0020);
    chk("sm_wdata", bus.mem_wdata,       32'hAABB_CCDD);
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    chk("sm_ack_fill",  {31'b0, bus.fill_we}, 32'd0);
    chk("sm_ack_stall", {31'b0, bus.stall},   32'd0);
    chk("sm_ack_req",   {31'b0, bus.mem_req}, 32'd0);
    req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    chk("sm_idle_fill", {31'b0, bus.fill_we}, 32'd0);

    // Load hit at 0x8.
    req(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1);
    chk("lh_stall", {31'b0, bus.stall}, 32'd0);
    step();
    chk("lh_req",    {31'b0, bus.mem_req}, 32'd0);
    chk("lh_fill",   {31'b0, bus.fill_we}, 32'd0);
    chk("lh_stall2", {31'b0, bus.stall},   32'd0);
    req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();

    // Timeout: mem_ready never arrives.
    req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0);
    step();
    repeat (63) step();
    chk("to_w64_req", {31'b0, bus.mem_req}, 32'd1);
    chk("to_w64_err", {31'b0, bus.err},     32'd0);
    step();
    chk("to_ack_req",   {31'b0, bus.mem_req}, 32'd0);
    chk("to_ack_err",   {31'b0, bus.err},     32'd1);
    chk("to_ack_fill",  {31'b0, bus.fill_we}, 32'd0);
    chk("to_ack_stall", {31'b0, bus.stall},   32'd0);
    req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) step();
    chk("to_err_sticky", {31'b0, bus.err}, 32'd1);
    rst = 1'b0;
    #1;
    chk("to_err_cleared", {31'b0, bus.err}, 32'd0);
    step();
    rst = 1'b1;
    step();

    // mem_ready on the 64th wait cycle: completion wins.
    req(1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b0);
    step();
    repeat (63) step();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h55AA_55AA;
    step();
    bus.mem_ready = 1'b0;
    chk("t64_err",       {31'b0, bus.err},     32'd0);
    chk("t64_fill_we",   {31'b0, bus.fill_we}, 32'd1);
    chk("t64_fill_data", bus.fill_data,        32'h55AA_55AA);
    req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) step();
    chk("t64_err_later", {31'b0, bus.err}, 32'd0);

    // Reset asserted mid RD_WAIT.
    req(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    step();
    chk("rw_req", {31'b0, bus.mem_req}, 32'd1);
    rst = 1'b0;
    req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rw_rst_req",   {31'b0, bus.mem_req}, 32'd0);
    chk("rw_rst_stall", {31'b0, bus.stall},   32'd0);
    step();
    rst = 1'b1;
    step();

`ifdef DCACHE_PERF_EN
    chk("perf_hit0",  hit_count,  32'd0);
    chk("perf_miss0", miss_count, 32'd0);
    req(1'b1, 1'b0, 32'h0000_0008, 32'h0, 1'b1);
    repeat (3) step();
    req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step();
    load_miss_quick(32'h0000_0200);
    load_miss_quick(32'h0000_0300);
    chk("perf_hit3",  hit_count,  32'd3);
    chk("perf_miss2", miss_count, 32'd2);
    rst = 1'b0;
    #1;
    chk("perf_hit_rst",  hit_count,  32'd0);
    chk("perf_miss_rst", miss_count, 32'd0);
    step();
    rst = 1'b1;
    step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
